// File: rtl/dispatch_steer_if.sv
//------------------------------------------------------------------------------
// Module   : dispatch_steer_if
// Purpose  : Decoder-side push bus, unit issue ports and idle status for dispatch_steer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dispatch_steer_if #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [TAGW-1:0]        in_tag_i;
  logic                   in_alu_i;
  logic                   in_alu0_i;
  logic                   in_fpu_i;
  logic                   in_mem_i;
  logic                   in_fc_i;
  logic                   in_sync_i;
  logic                   in_fsync_i;
  logic                   in_memsb_i;
  logic                   in_memdb_i;
  logic                   alu0_valid_o;
  logic                   alu1_valid_o;
  logic                   fpu_valid_o;
  logic                   mem_valid_o;
  logic                   fc_valid_o;
  logic                   alu0_ready_i;
  logic                   alu1_ready_i;
  logic                   fpu_ready_i;
  logic                   mem_ready_i;
  logic                   fc_ready_i;
  logic [TAGW-1:0]        out_tag_o;
  logic                   all_idle_i;
  logic                   fpu_idle_i;
  logic                   mem_idle_i;
  logic                   barrier_stall_o;
  logic [$clog2(DEPTH):0] count_o;

  modport slave (
    input  in_valid_i, in_tag_i,
    input  in_alu_i, in_alu0_i, in_fpu_i, in_mem_i, in_fc_i,
    input  in_sync_i, in_fsync_i, in_memsb_i, in_memdb_i,
    input  alu0_ready_i, alu1_ready_i, fpu_ready_i, mem_ready_i, fc_ready_i,
    input  all_idle_i, fpu_idle_i, mem_idle_i,
    output in_ready_o,
    output alu0_valid_o, alu1_valid_o, fpu_valid_o, mem_valid_o, fc_valid_o,
    output out_tag_o, barrier_stall_o, count_o
  );

  modport master (
    output in_valid_i, in_tag_i,
    output in_alu_i, in_alu0_i, in_fpu_i, in_mem_i, in_fc_i,
    output in_sync_i, in_fsync_i, in_memsb_i, in_memdb_i,
    output alu0_ready_i, alu1_ready_i, fpu_ready_i, mem_ready_i, fc_ready_i,
    output all_idle_i, fpu_idle_i, mem_idle_i,
    input  in_ready_o,
    input  alu0_valid_o, alu1_valid_o, fpu_valid_o, mem_valid_o, fc_valid_o,
    input  out_tag_o, barrier_stall_o, count_o
  );
endinterface

`default_nettype wire

// File: rtl/dispatch_steer.sv
//------------------------------------------------------------------------------
// Module   : dispatch_steer
// Purpose  : In-order dispatch FIFO steering each head entry to one unit port,
//            holding SYNC/FSYNC/MEMSB/MEMDB barriers until their units drain.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dispatch_steer #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  dispatch_steer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = 9;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_BWAIT = 1'b1;

  // Flag layout: {sync, fsync, memsb, memdb, fc, mem, fpu, alu0, alu}
  logic [TAGW-1:0] r_tag_mem  [DEPTH];
  logic [FW-1:0]   r_flag_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [0:0]      r_st;
  logic [0:0]      w_st_nxt;

  logic          w_empty;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic [FW-1:0] w_head;
  logic          w_barrier;
  logic          w_cond;
  logic          w_nop;
  logic          w_handshake;
  logic          w_alu0_v;
  logic          w_alu1_v;
  logic          w_fpu_v;
  logic          w_mem_v;
  logic          w_fc_v;
  logic          w_stall;

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count != CW'(DEPTH));
  assign w_push     = bus.in_valid_i & w_in_ready;
  assign w_head     = r_flag_mem[r_rd_ptr];

  assign w_barrier = |w_head[8:5];
  assign w_nop     = (w_head == '0);
  assign w_cond    = w_head[8] ? bus.all_idle_i :
                     w_head[7] ? bus.fpu_idle_i : bus.mem_idle_i;

  assign w_handshake = (w_alu0_v & bus.alu0_ready_i) | (w_alu1_v & bus.alu1_ready_i) |
                       (w_fpu_v  & bus.fpu_ready_i)  | (w_mem_v  & bus.mem_ready_i)  |
                       (w_fc_v   & bus.fc_ready_i);

  assign w_pop = !w_empty & (w_barrier ? w_cond : (w_nop | w_handshake));

  // Storage is cleared on reset so the idle tag reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag_mem[i]  <= '0;
        r_flag_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_tag_mem[r_wr_ptr]  <= bus.in_tag_i;
      r_flag_mem[r_wr_ptr] <= {bus.in_sync_i, bus.in_fsync_i, bus.in_memsb_i, bus.in_memdb_i,
                               bus.in_fc_i, bus.in_mem_i, bus.in_fpu_i, bus.in_alu0_i,
                               bus.in_alu_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_st <= ST_RUN;
    else         r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_RUN:   if (!w_empty && w_barrier && !w_cond) w_st_nxt = ST_BWAIT;
      ST_BWAIT: if (w_cond) w_st_nxt = ST_RUN;
      default:  w_st_nxt = ST_RUN;
    endcase
  end

  // Generic ALU valid looks at both readies: ALU1 by default, ALU0 only when ALU1 is busy.
  always_comb begin
    w_alu0_v = 1'b0;
    w_alu1_v = 1'b0;
    w_fpu_v  = 1'b0;
    w_mem_v  = 1'b0;
    w_fc_v   = 1'b0;
    w_stall  = 1'b0;
    if (!w_empty) begin
      if (w_barrier) begin
        w_stall = !w_cond;
      end else if (r_st == ST_RUN) begin
        if (w_head[4])      w_fc_v   = 1'b1;
        else if (w_head[3]) w_mem_v  = 1'b1;
        else if (w_head[2]) w_fpu_v  = 1'b1;
        else if (w_head[1]) w_alu0_v = 1'b1;
        else if (w_head[0]) begin
          if (!bus.alu1_ready_i && bus.alu0_ready_i) w_alu0_v = 1'b1;
          else                                        w_alu1_v = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready_o      = w_in_ready;
  assign bus.alu0_valid_o    = w_alu0_v;
  assign bus.alu1_valid_o    = w_alu1_v;
  assign bus.fpu_valid_o     = w_fpu_v;
  assign bus.mem_valid_o     = w_mem_v;
  assign bus.fc_valid_o      = w_fc_v;
  assign bus.out_tag_o       = r_tag_mem[r_rd_ptr];
  assign bus.barrier_stall_o = w_stall;
  assign bus.count_o         = r_count;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_steer.sv
//------------------------------------------------------------------------------
// Module   : tb_dispatch_steer
// Purpose  : Directed and random stimulus for dispatch_steer against a queue model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dispatch_steer;

  localparam int DEPTH = 4;
  localparam int TAGW  = 6;

  // Flag vectors: {sync, fsync, memsb, memdb, fc, mem, fpu, alu0, alu}
  localparam logic [8:0] F_NOP  = 9'h000;
  localparam logic [8:0] F_ALU  = 9'h001;
  localparam logic [8:0] F_ALU0 = 9'h002;
  localparam logic [8:0] F_MEM  = 9'h008;
  localparam logic [8:0] F_FC   = 9'h010;
  localparam logic [8:0] F_SYNC = 9'h100;
  // Ready vectors: {fc, mem, fpu, alu1, alu0}; idle vectors: {all, fpu, mem}
  localparam logic [4:0] R_ALU0 = 5'b00001;
  localparam logic [4:0] R_ALU1 = 5'b00010;
  localparam logic [4:0] R_MEM  = 5'b01000;
  localparam logic [4:0] R_FC   = 5'b10000;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [8:0]      fl;
  } ent_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  ent_t q[$];
  logic [4:0] cur_rdy;
  logic [2:0] cur_idl;

  dispatch_steer_if #(.DEPTH(DEPTH), .TAGW(TAGW)) bus ();

  dispatch_steer #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [4:0] dut_valids();
    return {bus.fc_valid_o, bus.mem_valid_o, bus.fpu_valid_o, bus.alu1_valid_o, bus.alu0_valid_o};
  endfunction

  // Reference: what the head should present and whether it leaves this cycle.
  task automatic model(output logic [4:0] ev, output logic ret, output logic stall);
    logic [8:0] fl;
    ev = '0; ret = 1'b0; stall = 1'b0;
    if (q.size() != 0) begin
      fl = q[0].fl;
      if (fl[8])              ret = cur_idl[2];
      else if (fl[7])         ret = cur_idl[1];
      else if (fl[6] | fl[5]) ret = cur_idl[0];
      else if (fl[4]) begin ev = 5'b10000; ret = cur_rdy[4]; end
      else if (fl[3]) begin ev = 5'b01000; ret = cur_rdy[3]; end
      else if (fl[2]) begin ev = 5'b00100; ret = cur_rdy[2]; end
      else if (fl[1]) begin ev = 5'b00001; ret = cur_rdy[0]; end
      else if (fl[0]) begin
        if (cur_rdy[1])      begin ev = 5'b00010; ret = 1'b1; end
        else if (cur_rdy[0]) begin ev = 5'b00001; ret = 1'b1; end
        else                 begin ev = 5'b00010; ret = 1'b0; end
      end else ret = 1'b1;
      stall = (|fl[8:5]) && !ret;
    end
  endtask

  // One cycle: drive at the falling edge, check 1ns later, advance model on the rising edge.
  task automatic step(input logic v, input logic [TAGW-1:0] tg, input logic [8:0] fl,
                      input logic [4:0] rdy, input logic [2:0] idl);
    logic [4:0] ev;
    logic ret, stall, push;
    bus.in_valid_i = v;
    bus.in_tag_i   = tg;
    {bus.in_sync_i, bus.in_fsync_i, bus.in_memsb_i, bus.in_memdb_i,
     bus.in_fc_i, bus.in_mem_i, bus.in_fpu_i, bus.in_alu0_i, bus.in_alu_i} = fl;
    {bus.fc_ready_i, bus.mem_ready_i, bus.fpu_ready_i, bus.alu1_ready_i, bus.alu0_ready_i} = rdy;
    {bus.all_idle_i, bus.fpu_idle_i, bus.mem_idle_i} = idl;
    cur_rdy = rdy;
    cur_idl = idl;
    #1;
    model(ev, ret, stall);
    chk("valids", 32'(dut_valids()), 32'(ev));
    chk("in_ready", 32'(bus.in_ready_o), 32'(q.size() < DEPTH));
    chk("count", 32'(bus.count_o), 32'(q.size()));
    chk("stall", 32'(bus.barrier_stall_o), 32'(stall));
    if (q.size() != 0) chk("tag", 32'(bus.out_tag_o), 32'(q[0].tag));
    push = v && (q.size() < DEPTH);
    @(posedge clk);
    if (ret)  void'(q.pop_front());
    if (push) q.push_back('{tag: tg, fl: fl});
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valids"}, 32'(dut_valids()), 32'd0);
    chk({nm, "_count"}, 32'(bus.count_o), 32'd0);
    chk({nm, "_ready"}, 32'(bus.in_ready_o), 32'd1);
    chk({nm, "_stall"}, 32'(bus.barrier_stall_o), 32'd0);
    chk({nm, "_tag"}, 32'(bus.out_tag_o), 32'd0);
  endtask

  initial begin
    logic [8:0] rfl;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_tag_i   = '0;
    {bus.in_sync_i, bus.in_fsync_i, bus.in_memsb_i, bus.in_memdb_i,
     bus.in_fc_i, bus.in_mem_i, bus.in_fpu_i, bus.in_alu0_i, bus.in_alu_i} = '0;
    {bus.fc_ready_i, bus.mem_ready_i, bus.fpu_ready_i, bus.alu1_ready_i, bus.alu0_ready_i} = '0;
    {bus.all_idle_i, bus.fpu_idle_i, bus.mem_idle_i} = '0;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU op on ALU1
    step(1'b1, 6'd5, F_ALU, R_ALU1, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_ALU1, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_ALU1, 3'b000);

    // Fill with MEM ops, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, TAGW'(i), F_MEM, 5'b0, 3'b000);
    step(1'b1, 6'd33, F_MEM, 5'b0, 3'b000);
    for (int i = 0; i < 4; i++) step(1'b0, 6'd0, F_NOP, R_MEM, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_MEM, 3'b000);

    // ALU fallback to ALU0; dedicated ALU0 op held without ALU1 valid
    step(1'b1, 6'd7, F_ALU, R_ALU0, 3'b000);
    step(1'b1, 6'd8, F_ALU0, R_ALU0, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_ALU1, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_ALU1, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_ALU0, 3'b000);

    // SYNC barrier ahead of an FC op
    step(1'b1, 6'd0, F_SYNC, 5'b0, 3'b000);
    step(1'b1, 6'd9, F_FC, 5'b0, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, F_NOP, R_FC, 3'b000);
    step(1'b0, 6'd0, F_NOP, R_FC, 3'b100);
    step(1'b0, 6'd0, F_NOP, R_FC, 3'b000);

    // Steady push and pop at occupancy 2 across pointer wrap
    step(1'b1, 6'd20, F_ALU, 5'b0, 3'b000);
    step(1'b1, 6'd21, F_ALU, 5'b0, 3'b000);
    for (int i = 0; i < 8; i++) step(1'b1, TAGW'(22 + i), F_ALU, R_ALU1, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, F_NOP, R_ALU1, 3'b000);

    // Asynchronous reset while waiting on a barrier with 3 entries
    step(1'b1, 6'd40, F_SYNC, 5'b0, 3'b000);
    step(1'b1, 6'd41, F_ALU, 5'b0, 3'b000);
    step(1'b1, 6'd42, F_ALU, 5'b0, 3'b000);
    step(1'b0, 6'd0, F_NOP, 5'b0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 6'd0, F_NOP, 5'b11111, 3'b111);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 4) == 0) rfl = 9'($urandom);
      else                           rfl = 9'(10'd1 << $urandom_range(0, 9));
      step(1'($urandom_range(0, 2) != 0), TAGW'($urandom), rfl,
           5'($urandom), 3'($urandom_range(0, 7) & $urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
